ram_burst_master: RTL and testbench

Initiator-side controller for the 256x32 single-port distributed RAM. It accepts burst commands over a valid/ready handshake and drives the RAM's address, write-enable and data-in pins. For write bursts it pulls beats from a write stream; for read bursts it streams beats out on a read stream. It absorbs the RAM's one-cycle registered read latency and supports full backpressure without losing data. The block sits between the datapath clients and the RAM instance in the same clock domain.

---
 rtl/ram_burst_master.sv | 165 ++++++++++++++++
 tb/tb_ram_burst_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst initiator for the 256x32 single-port RAM with a 2-deep read FIFO.
// Optional beat counter port when RAM_BURST_STATS_EN is defined.
module ram_burst_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_BURST_STATS_EN
    ,
    output logic [31:0]       beat_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] cur_addr, cur_addr_n;
    logic [ADDR_W-1:0] remaining, remaining_n;
    logic              inflight;
    logic              inflight_last;
    logic              issue;

    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wptr;
    logic              rptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;
    logic [2:0]        occ;

    assign push = inflight;
    assign pop  = rd_valid && rd_ready;

    // Occupancy seen by the issue logic already credits this cycle's pop,
    // which keeps a full-rate stream going while rd_ready stays high.
    assign occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign rd_valid = (count != 2'd0);
    assign rd_data  = rd_valid ? fifo_data[rptr] : '0;
    assign rd_last  = rd_valid & fifo_last[rptr];

    assign busy     = (state != IDLE);
    assign ram_addr = cur_addr;
    assign ram_din  = wr_data;

    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        remaining_n = remaining;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        ram_we      = 1'b0;
        issue       = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_n  = cmd_addr;
                    remaining_n = cmd_len;
                    state_n     = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                ram_we   = wr_valid;
                if (wr_valid) begin
                    cur_addr_n  = cur_addr + 1'b1;
                    remaining_n = remaining - 1'b1;
                    if (remaining == '0)
                        state_n = IDLE;
                end
            end
            READ: begin
                if (occ < 3'd2) begin
                    issue       = 1'b1;
                    cur_addr_n  = cur_addr + 1'b1;
                    remaining_n = remaining - 1'b1;
                    if (remaining == '0)
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifo_last[rptr])
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_n;
            cur_addr      <= cur_addr_n;
            remaining     <= remaining_n;
            inflight      <= issue;
            inflight_last <= issue && (remaining == '0);
        end
    end

    // ram_dout belongs to the address issued in the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wptr         <= 1'b0;
            rptr         <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wptr] <= ram_dout;
                fifo_last[wptr] <= inflight_last;
                wptr            <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef RAM_BURST_STATS_EN
    logic wr_fire;

    assign wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_count <= '0;
        else
            beat_count <= beat_count + {31'd0, wr_fire} + {31'd0, pop};
    end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master with a behavioural 256x32 RAM.
// Checks beat_count too when RAM_BURST_STATS_EN is defined.
module tb_ram_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = 32'h5A5A_1234;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
`ifdef RAM_BURST_STATS_EN
    logic [31:0] beat_count;
`endif

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int rd_cnt = 0;

    logic [39:0] wexp [$];
    logic [32:0] rdexp [$];
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    ram_burst_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef RAM_BURST_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= '0;
            ram_dout <= '0;
        end else begin
            if (ram_we)
                mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                logic [39:0] e;
                we_cnt++;
                if (wexp.size() == 0) begin
                    chk("wr_extra", 64'(ram_addr), 64'hFFFF);
                end else begin
                    e = wexp.pop_front();
                    chk("wr_addr", 64'(ram_addr), 64'(e[39:32]));
                    chk("wr_data", 64'(ram_din), 64'(e[31:0]));
                end
            end
            if (rd_valid && rd_ready) begin
                logic [32:0] r;
                rd_cnt++;
                if (rdexp.size() == 0) begin
                    chk("rd_extra", 64'(rd_data), 64'hFFFF_FFFF_F);
                end else begin
                    r = rdexp.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(r[31:0]));
                    chk("rd_last", 64'(rd_last), 64'(r[32]));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [7:0] a,
                            input logic [7:0] len);
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_rd(input logic [31:0] d, input logic l);
        rdexp.push_back({l, d});
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] len,
                            input logic [31:0] base);
        wait_idle();
        for (int i = 0; i <= int'(len); i++)
            wexp.push_back({8'(int'(a) + i), 32'(base + 32'(i))});
        send_cmd(1'b1, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_wr", 64'(busy), 64'd0);
        chk("cmd_rdy_after_wr", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] len,
                           input int mode, input bit lat);
        int cyc = 0;
        int tgt;
        wait_idle();
        tgt = rd_cnt + int'(len) + 1;
        send_cmd(1'b0, a, len);
        while (rd_cnt < tgt && cyc < 2000) begin
            if (mode == 0)
                rd_ready = 1'b1;
            else
                rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            if (lat && cyc < 3)
                chk("rd_latency", 64'(rd_valid), 64'(cyc == 2));
            @(posedge clk);
            #1;
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_count", 64'(rd_cnt), 64'(tgt));
        @(negedge clk);
        chk("idle_after_rd", 64'(busy), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_last", 64'(rd_last), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_din", 64'(ram_din), 64'h5A5A_1234);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        rst = 1'b0;

        do_write(8'h10, 8'd3, 32'hA0);
        chk("we_cycles", 64'(we_cnt), 64'd4);

        for (int i = 0; i < 4; i++)
            push_rd(32'hA0 + 32'(i), i == 3);
        do_read(8'h10, 8'd3, 0, 1'b1);

        for (int i = 0; i < 8; i++)
            push_rd(i < 4 ? 32'hA0 + 32'(i) : 32'h0, i == 7);
        do_read(8'h10, 8'd7, 1, 1'b0);

        do_write(8'hFE, 8'd3, 32'd1);
        for (int i = 0; i < 4; i++)
            push_rd(32'd1 + 32'(i), i == 3);
        do_read(8'hFE, 8'd3, 0, 1'b0);

`ifdef RAM_BURST_STATS_EN
        chk("beat_count", 64'(beat_count), 64'd24);
`endif

        begin
            int n = 0;
            int tgt;
            wait_idle();
            for (int i = 0; i < 8; i++)
                push_rd(i < 4 ? 32'd1 + 32'(i) : 32'h0, i == 7);
            tgt = rd_cnt + 2;
            send_cmd(1'b0, 8'hFE, 8'd7);
            rd_ready = 1'b1;
            while (rd_cnt < tgt && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("abort_pre_valid", 64'(rd_valid), 64'd1);
            #2;
            rst = 1'b1;
            #1;
            chk("abort_rd_valid", 64'(rd_valid), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_ram_we", 64'(ram_we), 64'd0);
            chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
            rdexp.delete();
            rd_ready = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end

        for (int i = 0; i < 4; i++)
            push_rd(32'hA0 + 32'(i), i == 3);
        do_read(8'h10, 8'd3, 0, 1'b0);

        chk("wexp_left", 64'(wexp.size()), 64'd0);
        chk("rdexp_left", 64'(rdexp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
